// File: rtl/aip_pkg.sv
// Shared definitions for the AIP port arbiter.
//   AIP_CFG_W : default AIP config bus width
//   ST_*      : arbiter FSM state encoding
//   rr_next() : round-robin pointer advance, wrapping at n
package aip_pkg;
  localparam int AIP_CFG_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic logic [2:0] rr_next(input logic [2:0] k, input int n);
    return (int'(k) >= n - 1) ? 3'd0 : k + 3'd1;
  endfunction
endpackage

// File: rtl/aip_port_arbiter_rr.sv
// Combinational round-robin picker.
//   i_req : request vector
//   i_ptr : index that has first claim this round
//   o_gnt : one-hot pick (0 when no request)
//   o_idx : index of the pick
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  int w_j;

  // Scan from furthest to nearest so the nearest requester at/after ptr wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end
endmodule

// File: rtl/aip_port_arbiter.sv
// Shares one AIP slave port among N_REQ requesters: round-robin grant, bus lock
// while the owner holds i_req, idle watchdog, interrupt routed to the job owner.
//   i_clk/i_rst_a            : clock, async active-low reset
//   i_req/i_read/i_write/i_start, i_conf_dbus, i_data_in : per-requester side
//   o_gnt/o_owner/o_timeout/o_int_req/o_data_out         : status to requesters
//   o_configAIP/o_dataInAIP/o_readAIP/o_writeAIP/o_startAIP, i_dataOutAIP, i_intAIP : slave side
module aip_port_arbiter
  import aip_pkg::*;
#(
  parameter int DATA_WORD = 32,
  parameter int N_REQ     = 3,
  parameter int CFG_W     = AIP_CFG_W,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst_a,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*CFG_W-1:0]    i_conf_dbus,
  input  logic [N_REQ-1:0]          i_read,
  input  logic [N_REQ-1:0]          i_write,
  input  logic [N_REQ-1:0]          i_start,
  input  logic [N_REQ*DATA_WORD-1:0] i_data_in,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [DATA_WORD-1:0]      o_data_out,
  output logic [N_REQ-1:0]          o_int_req,
  output logic [2:0]                o_owner,
  output logic                      o_timeout,
  output logic [CFG_W-1:0]          o_configAIP,
  output logic [DATA_WORD-1:0]      o_dataInAIP,
  output logic                      o_readAIP,
  output logic                      o_writeAIP,
  output logic                      o_startAIP,
  input  logic [DATA_WORD-1:0]      i_dataOutAIP,
  input  logic                      i_intAIP
);
  localparam int IW   = $clog2(N_REQ);
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]       r_state;
  logic [N_REQ-1:0] r_gnt, r_pend;
  logic [IW-1:0]    r_owner, r_ptr, r_job;
  logic [WD_W-1:0]  r_wd;
  logic             r_timeout, r_int_d;

  logic [N_REQ-1:0] w_arb_gnt, w_clr, w_set;
  logic [IW-1:0]    w_arb_idx;
  logic             w_busy, w_rd, w_wr, w_st, w_act, w_own_req, w_expire, w_rise;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_busy    = (r_state == ST_BUSY);
  assign w_rd      = w_busy & i_read[r_owner];
  assign w_wr      = w_busy & i_write[r_owner];
  assign w_st      = w_busy & i_start[r_owner];
  assign w_act     = w_rd | w_wr | w_st;
  assign w_own_req = i_req[r_owner];
  // Revoke on the idle cycle that would take the count to TIMEOUT.
  assign w_expire  = (TIMEOUT != 0) && w_busy && !w_act && (r_wd == WD_W'(TIMEOUT - 1));
  assign w_rise    = i_intAIP & ~r_int_d;
  // r_gnt is one-hot of the owner while BUSY, so it doubles as the clear mask.
  assign w_clr     = (w_rd | w_st) ? r_gnt : '0;
  assign w_set     = w_rise ? (N_REQ'(1) << r_job) : '0;

  always_ff @(posedge i_clk or negedge i_rst_a) begin
    if (!i_rst_a) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_job     <= '0;
      r_wd      <= '0;
      r_pend    <= '0;
      r_timeout <= 1'b0;
      r_int_d   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_int_d   <= i_intAIP;
      case (r_state)
        ST_IDLE: if (|i_req) begin
          r_state <= ST_BUSY;
          r_gnt   <= w_arb_gnt;
          r_owner <= w_arb_idx;
          r_ptr   <= IW'(rr_next(3'(w_arb_idx), N_REQ));
          r_wd    <= '0;
        end
        ST_BUSY: begin
          if (!w_own_req) begin
            r_state <= ST_GAP;
            r_gnt   <= '0;
          end else if (w_expire) begin
            r_state   <= ST_GAP;
            r_gnt     <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_wd <= w_act ? '0 : r_wd + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_st) r_job <= r_owner;
      // Set wins over clear for the same requester.
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  always_comb begin
    o_configAIP = '0;
    o_dataInAIP = '0;
    o_data_out  = '0;
    if (w_busy) begin
      o_configAIP = i_conf_dbus[int'(r_owner)*CFG_W +: CFG_W];
      o_dataInAIP = i_data_in[int'(r_owner)*DATA_WORD +: DATA_WORD];
      o_data_out  = i_dataOutAIP;
    end
  end

  assign o_readAIP  = w_rd;
  assign o_writeAIP = w_wr;
  assign o_startAIP = w_st;
  assign o_gnt      = r_gnt;
  assign o_owner    = 3'(r_owner);
  assign o_int_req  = r_pend;
  assign o_timeout  = r_timeout;
endmodule

// File: tb/tb_aip_port_arbiter.sv
module tb_aip_port_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int CW = 5;
  localparam int TO = 16;

  logic          clk = 0, rst_n = 0;
  logic [N-1:0]  req = '0, rd = '0, wr = '0, st = '0;
  logic [N*CW-1:0] conf = '0;
  logic [N*DW-1:0] din = '0;
  logic [DW-1:0] dout = '0;
  logic          intr = 0;

  logic [N-1:0]  gnt, int_req;
  logic [DW-1:0] data_out, data_aip;
  logic [2:0]    owner;
  logic          tmo, rd_aip, wr_aip, st_aip;
  logic [CW-1:0] cfg_aip;

  int n_chk = 0, n_fail = 0;

  aip_port_arbiter #(.DATA_WORD(DW), .N_REQ(N), .CFG_W(CW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_a(rst_n), .i_req(req), .i_conf_dbus(conf), .i_read(rd),
    .i_write(wr), .i_start(st), .i_data_in(din), .o_gnt(gnt), .o_data_out(data_out),
    .o_int_req(int_req), .o_owner(owner), .o_timeout(tmo), .o_configAIP(cfg_aip),
    .o_dataInAIP(data_aip), .o_readAIP(rd_aip), .o_writeAIP(wr_aip), .o_startAIP(st_aip),
    .i_dataOutAIP(dout), .i_intAIP(intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the bus, how long it has sat idle, the gap, pending ints.
  int      m_owner = -1, m_ptr = 0, m_idle = 0, m_job = 0;
  bit      m_gap = 0, m_to = 0, m_prev_int = 0;
  bit [N-1:0] m_pend = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_idle = 0; m_job = 0;
      m_gap = 0; m_to = 0; m_prev_int = 0; m_pend = '0;
      chk("rst gnt", gnt, 0);
      chk("rst strobes", {rd_aip, wr_aip, st_aip, tmo}, 0);
      chk("rst cfg/data", {cfg_aip, data_aip, data_out}, 0);
      chk("rst int/owner", {int_req, owner}, 0);
    end else begin
      bit busy, rise, act;
      bit [N-1:0] clr;
      int o, new_job;
      busy = (m_owner >= 0);
      o = busy ? m_owner : 0;
      chk("m gnt", gnt, busy ? (64'd1 << m_owner) : 0);
      if (busy) chk("m owner", owner, m_owner);
      chk("m read", rd_aip, busy && rd[o]);
      chk("m write", wr_aip, busy && wr[o]);
      chk("m start", st_aip, busy && st[o]);
      chk("m cfg", cfg_aip, busy ? (conf >> (o * CW)) & 5'h1f : 0);
      chk("m din", data_aip, busy ? (din >> (o * DW)) & 32'hffffffff : 0);
      chk("m dout", data_out, busy ? dout : 0);
      chk("m timeout", tmo, m_to);
      chk("m int_req", int_req, m_pend);
      // Advance the model with the inputs the next rising edge will see.
      rise = intr && !m_prev_int;
      clr = '0;
      new_job = m_job;
      m_to = 0;
      if (busy) begin
        act = rd[o] || wr[o] || st[o];
        if (rd[o] || st[o]) clr[o] = 1;
        if (st[o]) new_job = o;
        if (!req[o]) begin
          m_owner = -1; m_gap = 1;
        end else begin
          m_idle = act ? 0 : m_idle + 1;
          if (m_idle == TO) begin m_owner = -1; m_gap = 1; m_to = 1; end
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (req != 0) begin
        for (int s = 0; s < N; s++) begin
          int k;
          k = (m_ptr + s) % N;
          if (req[k]) begin m_owner = k; break; end
        end
        m_ptr = (m_owner + 1) % N;
        m_idle = 0;
      end
      m_pend = m_pend & ~clr;
      if (rise) m_pend[m_job] = 1;
      m_job = new_job;
      m_prev_int = intr;
    end
  end

  initial begin
    // 1: reset, single requester, same-cycle write forwarding
    repeat (2) @(posedge clk);
    #1;
    chk("t1 reset gnt", gnt, 0);
    rst_n = 1; req = 3'b001;
    tick();
    chk("t1 gnt", gnt, 3'b001);
    wr = 3'b001; conf[4:0] = 5'h02; din[31:0] = 32'hA5;
    #1;
    chk("t1 write", wr_aip, 1);
    chk("t1 cfg", cfg_aip, 5'h02);
    chk("t1 data", data_aip, 32'hA5);
    tick(); wr = '0;

    // 2: all request, owners drop one by one
    req = 3'b111; tick();
    chk("t2 lock", gnt, 3'b001);
    req = 3'b110; tick();
    chk("t2 gap0a", gnt, 0); tick();
    chk("t2 gap0b", gnt, 0); tick();
    chk("t2 gnt1", gnt, 3'b010);
    req = 3'b100; tick(2);
    chk("t2 gap1", gnt, 0); tick();
    chk("t2 gnt2", gnt, 3'b100);
    req = 3'b000; tick(2);

    // 3: non-owner write is dropped
    req = 3'b010; tick();
    chk("t3 gnt1", gnt, 3'b010);
    req = 3'b011; wr = 3'b001;
    #1;
    chk("t3 no write", wr_aip, 0);
    tick();
    chk("t3 held", gnt, 3'b010);
    wr = '0; req = 3'b001; tick(3);
    chk("t3 gnt0", gnt, 3'b001);
    req = 3'b000; tick(2);

    // 4: watchdog on idle owner 2
    req = 3'b101; tick();
    chk("t4 gnt2", gnt, 3'b100);
    tick(15);
    chk("t4 no tmo yet", tmo, 0);
    chk("t4 still owned", gnt, 3'b100);
    tick();
    chk("t4 tmo", tmo, 1);
    chk("t4 revoked", gnt, 0);
    tick();
    chk("t4 tmo pulse", tmo, 0);
    tick();
    chk("t4 next gnt", gnt, 3'b001);

    // 5: interrupt routed to job owner 0 while 1 holds the bus
    st = 3'b001; tick(); st = '0;
    req = 3'b010; tick(3);
    chk("t5 gnt1", gnt, 3'b010);
    intr = 1; tick(); intr = 0;
    chk("t5 int", int_req, 3'b001);
    req = 3'b001; tick(3);
    chk("t5 regnt0", gnt, 3'b001);
    chk("t5 int held", int_req, 3'b001);
    rd = 3'b001; tick(); rd = '0;
    chk("t5 int clr", int_req, 0);

    // 6: async reset mid-transaction
    req = 3'b011; wr = 3'b001; st = 3'b001;
    #1; rst_n = 0; #1;
    chk("t6 gnt", gnt, 0);
    chk("t6 strobes", {wr_aip, st_aip, rd_aip}, 0);
    chk("t6 cfg", cfg_aip, 0);
    wr = '0; st = '0; tick();
    rst_n = 1; tick();
    chk("t6 restart at 0", gnt, 3'b001);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bit calm;
      calm = ((c / 500) % 2) == 1;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(calm ? 63 : 7) == 0) req[b] = ~req[b];
        rd[b] = $urandom_range(calm ? 39 : 3) == 0;
        wr[b] = $urandom_range(calm ? 39 : 3) == 0;
        st[b] = $urandom_range(calm ? 59 : 7) == 0;
      end
      conf = N*CW'($urandom);
      din  = {$urandom, $urandom, $urandom};
      dout = $urandom;
      intr = $urandom_range(5) == 0;
      rst_n = ($urandom_range(799) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
